cache_mesi_fsm: RTL and testbench

//  Per-line MESI coherence controller for one private cache line in a snooping multiprocessor.

---
 rtl/cache_mesi_fsm.sv | 61 ++++++
 tb/tb_cache_mesi_fsm.sv | 117 +++++++++++
 2 files changed

// File: rtl/cache_mesi_fsm.sv
// cache_mesi_fsm: per-line MESI coherence state machine with registered bus request outputs
module cache_mesi_fsm (
  input  logic clk,
  input  logic rstb,
  input  logic PrRd,
  input  logic PrWr,
  input  logic BusRd_in,
  input  logic BusRdX_in,
  input  logic BusUpgr_in,
  input  logic C_in,
  output logic BusRd_out,
  output logic BusRdX_out,
  output logic BusUpgr_out,
  output logic BusUpgr_out_new,
  output logic Flush
);
  typedef enum logic [1:0] {I = 2'b00, S = 2'b01, E = 2'b10, M = 2'b11} state_t;
  state_t state_q;
  logic rd_q, rdx_q, upg_q, flush_q;
  logic snoop;
  assign snoop = BusRdX_in | BusUpgr_in;
  assign BusRd_out = rd_q;
  assign BusRdX_out = rdx_q;
  assign BusUpgr_out = upg_q;
  assign BusUpgr_out_new = upg_q;
  assign Flush = flush_q;
  // line state and one-cycle bus outputs; snoops outrank local requests, writes outrank reads
  always_ff @(posedge clk) begin
    rd_q <= 1'b0;
    rdx_q <= 1'b0;
    upg_q <= 1'b0;
    flush_q <= 1'b0;
    if (!rstb) state_q <= I;
    else begin
      case (state_q)
        I: if (!(snoop | BusRd_in)) begin
          if (PrWr) begin
            state_q <= M;
            rdx_q <= 1'b1;
          end else if (PrRd) begin
            state_q <= C_in ? S : E;
            rd_q <= 1'b1;
          end
        end
        S: if (snoop) state_q <= I;
          else if (!BusRd_in && PrWr) begin
            state_q <= M;
            upg_q <= 1'b1;
          end
        E: if (snoop) state_q <= I;
          else if (BusRd_in) state_q <= S;
          else if (PrWr) state_q <= M;
        M: if (snoop | BusRd_in) begin
          state_q <= snoop ? I : S;
          flush_q <= 1'b1;
        end
        default: state_q <= I;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mesi_fsm.sv
// tb_cache_mesi_fsm: table-driven directed check of MESI transitions and bus outputs
module tb_cache_mesi_fsm;
  logic clk = 1'b0;
  logic rstb, PrRd, PrWr, BusRd_in, BusRdX_in, BusUpgr_in, C_in;
  logic BusRd_out, BusRdX_out, BusUpgr_out, BusUpgr_out_new, Flush;
  int errors = 0;
  int checks = 0;

  // inputs: rstb rd wr brd brdx bupg c ; expected: state, {rd rdx upg flush}
  typedef struct packed {
    logic [6:0] in;
    logic [1:0] st;
    logic [3:0] out;
  } vec_t;
  vec_t tbl[$];

  localparam logic [1:0] SI = 2'b00, SS = 2'b01, SE = 2'b10, SM = 2'b11;

  cache_mesi_fsm dut (
    .clk(clk), .rstb(rstb), .PrRd(PrRd), .PrWr(PrWr), .BusRd_in(BusRd_in),
    .BusRdX_in(BusRdX_in), .BusUpgr_in(BusUpgr_in), .C_in(C_in),
    .BusRd_out(BusRd_out), .BusRdX_out(BusRdX_out), .BusUpgr_out(BusUpgr_out),
    .BusUpgr_out_new(BusUpgr_out_new), .Flush(Flush)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [6:0] in);
    @(negedge clk);
    {rstb, PrRd, PrWr, BusRd_in, BusRdX_in, BusUpgr_in, C_in} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic [3:0] out);
    logic [3:0] got;
    got = {BusRd_out, BusRdX_out, BusUpgr_out, Flush};
    checks++;
    if (dut.state_q !== st || got !== out || BusUpgr_out_new !== BusUpgr_out) begin
      errors++;
      $display("FAIL %s: state=%b outs(rd,rdx,upg,fl)=%b upg_new=%b, required state=%b outs=%b upg_new=%b",
               name, dut.state_q, got, BusUpgr_out_new, st, out, out[1]);
    end
  endtask

  initial begin
    int pulses;
    {rstb, PrRd, PrWr, BusRd_in, BusRdX_in, BusUpgr_in, C_in} = '0;
    tbl.push_back({7'b0000000, SI, 4'b0000}); // reset
    tbl.push_back({7'b0000000, SI, 4'b0000}); // reset
    tbl.push_back({7'b1000000, SI, 4'b0000}); // idle I
    tbl.push_back({7'b1010000, SM, 4'b0100}); // I PrWr -> M BusRdX
    tbl.push_back({7'b1000000, SM, 4'b0000}); // M idle
    tbl.push_back({7'b1000100, SI, 4'b0001}); // M BusRdX -> I Flush
    tbl.push_back({7'b1000000, SI, 4'b0000}); // I idle
    tbl.push_back({7'b1100001, SS, 4'b1000}); // I PrRd C=1 -> S BusRd
    tbl.push_back({7'b1010000, SM, 4'b0010}); // S PrWr -> M BusUpgr
    tbl.push_back({7'b1001000, SS, 4'b0001}); // M BusRd -> S Flush
    tbl.push_back({7'b1000110, SI, 4'b0000}); // S BusRdX+BusUpgr -> I
    tbl.push_back({7'b1011110, SI, 4'b0000}); // I all snoops + PrWr -> I
    tbl.push_back({7'b1100000, SE, 4'b1000}); // I PrRd C=0 -> E BusRd
    tbl.push_back({7'b1100000, SE, 4'b0000}); // E PrRd held
    tbl.push_back({7'b1010000, SM, 4'b0000}); // E PrWr -> M silent
    tbl.push_back({7'b1010000, SM, 4'b0000}); // M PrWr held
    tbl.push_back({7'b1000010, SI, 4'b0001}); // M BusUpgr -> I Flush
    tbl.push_back({7'b1100000, SE, 4'b1000}); // I PrRd C=0 -> E
    tbl.push_back({7'b1000100, SI, 4'b0000}); // E BusRdX -> I no Flush
    tbl.push_back({7'b1100001, SS, 4'b1000}); // I PrRd C=1 -> S
    tbl.push_back({7'b1011000, SS, 4'b0000}); // S BusRd beats PrWr
    tbl.push_back({7'b1000010, SI, 4'b0000}); // S BusUpgr -> I
    tbl.push_back({7'b1110000, SM, 4'b0100}); // I PrRd&PrWr -> M BusRdX
    tbl.push_back({7'b1110000, SM, 4'b0000}); // M PrRd&PrWr -> M
    tbl.push_back({7'b1001010, SI, 4'b0001}); // M snoop beats BusRd -> I Flush
    tbl.push_back({7'b1100000, SE, 4'b1000}); // I PrRd -> E
    tbl.push_back({7'b1001000, SS, 4'b0000}); // E BusRd -> S
    tbl.push_back({7'b1110001, SM, 4'b0010}); // S PrRd&PrWr -> M BusUpgr
    tbl.push_back({7'b1011000, SS, 4'b0001}); // M BusRd beats PrWr -> S Flush
    tbl.push_back({7'b1100000, SS, 4'b0000}); // S PrRd C ignored
    tbl.push_back({7'b1001000, SS, 4'b0000}); // S BusRd self-loop
    tbl.push_back({7'b0010000, SI, 4'b0000}); // reset beats PrWr
    tbl.push_back({7'b1001001, SI, 4'b0000}); // I BusRd ignored
    foreach (tbl[k]) begin
      step(tbl[k].in);
      check($sformatf("vec%0d", k), tbl[k].st, tbl[k].out);
    end

    // held PrWr from I yields a single BusRdX pulse
    pulses = 0;
    for (int n = 0; n < 4; n++) begin
      step(7'b1010000);
      pulses += int'(BusRdX_out);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL held_prwr_pulse: BusRdX pulses=%0d required=1", pulses);
    end
    check("held_prwr_state", SM, 4'b0000);

    // reset on the edge that would leave M clears the Flush and lands in I
    step(7'b0000100);
    check("rst_mid_flush", SI, 4'b0000);
    step(7'b1000000);
    check("after_rst_idle", SI, 4'b0000);

    // reset taking effect while an upgrade pulse is pending from S
    step(7'b1100001);
    check("seq_to_s", SS, 4'b1000);
    step(7'b1010000);
    check("seq_upg", SM, 4'b0010);
    step(7'b0000000);
    check("seq_rst_clears", SI, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
